// File: rtl/freq_meas.sv
// freq_meas: measures the period of a slow input signal in clk cycles.
// A rising edge of sig_in (after synchronisation) latches the current
// cycle count into period and pulses period_vld. If no edge arrives within
// TIMEOUT cycles, lost rises and period is cleared until timing restarts.
// Optional feature: define FREQ_MEAS_AVG4_EN to report the truncated mean of
// the last four raw periods (sliding window) instead of the raw period.
module freq_meas #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 100000000
) (
    input  logic             clk,
    input  logic             rst_n,      // active-high synchronous reset
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             period_vld,
    output logic             lost,
    output logic [5:0]       meas_cnt
);

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        LOST = 2'd2
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             vld_q;
    logic             lost_q;
    logic [5:0]       meas_cnt_q;
    logic             rise_s;

`ifdef FREQ_MEAS_AVG4_EN
    // win_q[0] is the most recent raw period; fill_q saturates at 4
    logic [WIDTH-1:0] win_q [4];
    logic [2:0]       fill_q;
    logic [WIDTH+1:0] sum_s;

    // New window = current count plus the three most recent stored periods
    assign sum_s = {2'b00, cnt_q} + {2'b00, win_q[0]}
                 + {2'b00, win_q[1]} + {2'b00, win_q[2]};
`endif

    // Rising edge of the synchronised input; fixed latency keeps periods exact
    assign rise_s = sync2_q & ~sync3_q;

    // Two-flop synchroniser plus history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Measurement FSM with registered outputs; an edge beats the timeout
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            vld_q      <= 1'b0;
            lost_q     <= 1'b0;
            meas_cnt_q <= 6'd0;
`ifdef FREQ_MEAS_AVG4_EN
            for (int i = 0; i < 4; i++) win_q[i] <= '0;
            fill_q <= 3'd0;
`endif
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef FREQ_MEAS_AVG4_EN
                    for (int i = 0; i < 4; i++) win_q[i] <= '0;
                    fill_q <= 3'd0;
`endif
                    if (rise_s) begin
                        cnt_q   <= ONE_C;
                        state_q <= MEAS;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                MEAS: begin
                    if (rise_s) begin
                        meas_cnt_q <= meas_cnt_q + 6'd1;
                        cnt_q      <= ONE_C;
`ifdef FREQ_MEAS_AVG4_EN
                        win_q[0] <= cnt_q;
                        win_q[1] <= win_q[0];
                        win_q[2] <= win_q[1];
                        win_q[3] <= win_q[2];
                        if (fill_q >= 3'd3) begin
                            period_q <= sum_s[WIDTH+1:2];
                            vld_q    <= 1'b1;
                        end else begin
                            vld_q    <= 1'b0;
                        end
                        if (fill_q != 3'd4) begin
                            fill_q <= fill_q + 3'd1;
                        end else begin
                            fill_q <= fill_q;
                        end
`else
                        period_q   <= cnt_q;
                        vld_q      <= 1'b1;
`endif
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q  <= LOST;
                        lost_q   <= 1'b1;
                        period_q <= '0;
                        cnt_q    <= '0;
`ifdef FREQ_MEAS_AVG4_EN
                        for (int i = 0; i < 4; i++) win_q[i] <= '0;
                        fill_q <= 3'd0;
`endif
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                LOST: begin
                    if (rise_s) begin
                        lost_q  <= 1'b0;
                        cnt_q   <= ONE_C;
                        state_q <= MEAS;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    lost_q  <= 1'b0;
                end
            endcase
        end
    end

    assign period     = period_q;
    assign period_vld = vld_q;
    assign lost       = lost_q;
    assign meas_cnt   = meas_cnt_q;

endmodule
